// File: rtl/prog_loader.sv
// Boot-time loader: assembles a little-endian byte stream into 32-bit words for the instruction RAM
// and holds the core in reset until the image is in. Define LOADER_CHECKSUM_EN for the trailing sum byte.
module prog_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  IN_VALID,
  input  logic [7:0]            IN_DATA,
  output logic                  IN_READY,
  output logic                  IMEM_WE,
  output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
  output logic [DATA_WIDTH-1:0] IMEM_WDATA,
  output logic                  CORE_RESET_N,
  output logic                  LOAD_DONE,
  output logic                  LOAD_ERR
);

  // Word counter is one bit wider than the address so a full-memory image can be counted.
  localparam int          CNT_W     = ADDR_WIDTH + 1;
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CSUM, S_RUN, S_ERR
  } state_t;
  localparam state_t S_AFTER_DATA = S_CSUM;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_RUN, S_ERR
  } state_t;
  localparam state_t S_AFTER_DATA = S_RUN;
`endif

  state_t                state_q, state_d;
  logic [7:0]            hdr_lo_q, hdr_lo_d;
  logic [CNT_W-1:0]      n_q, n_d;
  logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           asm_q, asm_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  core_rst_n_q, core_rst_n_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  logic                  accept;
  logic [15:0]           n_full;
  logic                  last_word;

  always_comb begin
    state_d    = state_q;
    hdr_lo_d   = hdr_lo_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    accept     = IN_VALID && ready_q;
    n_full     = {IN_DATA, hdr_lo_q};
    last_word  = (word_cnt_q == n_q - CNT_W'(1));

    case (state_q)
      S_HDR0: begin
        if (accept) begin
          hdr_lo_d = IN_DATA;
          state_d  = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          n_d = n_full[CNT_W-1:0];
          if ({1'b0, n_full} > MAX_WORDS) begin
            state_d = S_ERR;
          end else if (n_full == 16'd0) begin
            state_d = S_AFTER_DATA;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + IN_DATA;
`endif
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: asm_d[7:0]   = IN_DATA;
            2'd1: asm_d[15:8]  = IN_DATA;
            2'd2: asm_d[23:16] = IN_DATA;
            default: begin
              // The fourth byte goes straight into the write word; no need to stage it.
              we_d       = 1'b1;
              wdata_d    = {IN_DATA, asm_q};
              addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
              word_cnt_d = word_cnt_q + CNT_W'(1);
              if (last_word) begin
                state_d = S_AFTER_DATA;
              end
            end
          endcase
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = (IN_DATA == sum_q) ? S_RUN : S_ERR;
        end
      end
`endif
      default: begin
        // IDLE, RUN and ERR are the only states where START is honoured.
        if (START) begin
          state_d    = S_HDR0;
          word_cnt_d = '0;
          byte_idx_d = 2'd0;
          addr_d     = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = 8'd0;
`endif
        end
      end
    endcase

    ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
`ifdef LOADER_CHECKSUM_EN
    ready_d = ready_d || (state_d == S_CSUM);
`endif
    done_d       = (state_q == S_RUN) && !START;
    err_d        = (state_q == S_ERR) && !START;
    core_rst_n_d = done_d;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      hdr_lo_q     <= '0;
      n_q          <= '0;
      word_cnt_q   <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      ready_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hdr_lo_q     <= hdr_lo_d;
      n_q          <= n_d;
      word_cnt_q   <= word_cnt_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      ready_q      <= ready_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign IN_READY     = ready_q;
  assign IMEM_WE      = we_q;
  assign IMEM_ADDR    = addr_q;
  assign IMEM_WDATA   = wdata_q;
  assign CORE_RESET_N = core_rst_n_q;
  assign LOAD_DONE    = done_q;
  assign LOAD_ERR     = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of image loads plus stall and mid-word reset sequences.
module tb_prog_loader;
  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RESET, START, IN_VALID;
  logic [7:0]    IN_DATA;
  logic          IN_READY, IMEM_WE, CORE_RESET_N, LOAD_DONE, LOAD_ERR;
  logic [AW-1:0] IMEM_ADDR;
  logic [31:0]   IMEM_WDATA;

  always #5 CLK = ~CLK;

  prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .IN_READY(IN_READY), .IMEM_WE(IMEM_WE), .IMEM_ADDR(IMEM_ADDR), .IMEM_WDATA(IMEM_WDATA),
    .CORE_RESET_N(CORE_RESET_N), .LOAD_DONE(LOAD_DONE), .LOAD_ERR(LOAD_ERR)
  );

  typedef struct {
    logic [15:0] n;
    logic [31:0] w0, w1, w2;
    int          csum_delta;
    bit          send_body;
    bit          exp_done;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Write monitor: every strobe lands in the queues with the cycle it was seen in.
  int            cyc = 0;
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  int            last_wr_cyc = -1;
  int            done_cyc = -1;
  logic          prev_done = 1'b0;

  always @(posedge CLK) cyc = cyc + 1;

  always @(negedge CLK) begin
    if (IMEM_WE === 1'b1) begin
      wr_addr.push_back(IMEM_ADDR);
      wr_data.push_back(IMEM_WDATA);
      last_wr_cyc = cyc;
    end
    if (LOAD_DONE === 1'b1 && prev_done !== 1'b1) done_cyc = cyc;
    prev_done = LOAD_DONE;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input vec_t v, input int i);
    if (i == 0) return v.w0;
    if (i == 1) return v.w1;
    if (i == 2) return v.w2;
    return 32'(i);
  endfunction

  function automatic vec_t mk(input logic [15:0] n, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input int delta, input bit body,
                              input bit done, input bit err, input int nw);
    vec_t v;
    v.n = n; v.w0 = w0; v.w1 = w1; v.w2 = w2; v.csum_delta = delta;
    v.send_body = body; v.exp_done = done; v.exp_err = err; v.exp_writes = nw;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    IN_VALID = 1'b1;
    IN_DATA  = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge CLK);
      ok = (IN_READY === 1'b1);
      @(posedge CLK);
      #1;
    end
    IN_VALID = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: got ready=0 expected ready=1 for byte 0x%02h", b);
    end
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic run_load(input int id, input vec_t v);
    int          base;
    int          t0;
    int          nw;
    logic [7:0]  sum;
    logic [31:0] w;
    base = wr_addr.size();
    t0   = cyc;
    sum  = 8'd0;
    pulse_start();
    check("start_done_clear", {31'd0, LOAD_DONE}, 32'd0);
    check("start_err_clear", {31'd0, LOAD_ERR}, 32'd0);
    check("start_core_rst", {31'd0, CORE_RESET_N}, 32'd0);
    check("start_ready", {31'd0, IN_READY}, 32'd1);
    send_byte(v.n[7:0]);
    send_byte(v.n[15:8]);
    if (v.send_body) begin
      for (int i = 0; i < int'(v.n); i++) begin
        w = word_of(v, i);
        for (int b = 0; b < 4; b++) begin
          send_byte(w[8*b +: 8]);
          sum = sum + w[8*b +: 8];
        end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(sum + v.csum_delta[7:0]);
`endif
    end
    repeat (3) @(posedge CLK);
    #1;
    check("load_done", {31'd0, LOAD_DONE}, {31'd0, v.exp_done});
    check("load_err", {31'd0, LOAD_ERR}, {31'd0, v.exp_err});
    check("core_reset_n", {31'd0, CORE_RESET_N}, {31'd0, v.exp_done});
    check("ready_after", {31'd0, IN_READY}, 32'd0);
    nw = wr_addr.size() - base;
    check("write_count", 32'(nw), 32'(v.exp_writes));
    for (int i = 0; i < nw && i < v.exp_writes; i++) begin
      check("write_addr", 32'(wr_addr[base+i]), 32'(i));
      check("write_data", wr_data[base+i], word_of(v, i));
    end
`ifndef LOADER_CHECKSUM_EN
    if (v.exp_writes > 0) check("done_latency", 32'(done_cyc - last_wr_cyc), 32'd1);
`endif
    if (v.exp_done) check("done_rose", {31'd0, done_cyc > t0}, 32'd1);
    $display("load %0d: N=%0d writes=%0d done=%0b err=%0b core_rst_n=%0b",
             id, v.n, nw, LOAD_DONE, LOAD_ERR, CORE_RESET_N);
  endtask

  vec_t vecs[$];

  initial begin
    int base;
    vecs.push_back(mk(16'd3, 32'h0000_0013, 32'h0010_0093, 32'h0000_006F, 0, 1'b1, 1'b1, 1'b0, 3));
    vecs.push_back(mk(16'd0, 32'h0, 32'h0, 32'h0, 0, 1'b1, 1'b1, 1'b0, 0));
    vecs.push_back(mk(16'd1025, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b1, 0));
    vecs.push_back(mk(16'd1, 32'h0403_0201, 32'h0, 32'h0, 0, 1'b1, 1'b1, 1'b0, 1));
    vecs.push_back(mk(16'd1024, 32'd0, 32'd1, 32'd2, 0, 1'b1, 1'b1, 1'b0, 1024));
`ifdef LOADER_CHECKSUM_EN
    vecs.push_back(mk(16'd1, 32'h0403_0201, 32'h0, 32'h0, 1, 1'b1, 1'b0, 1'b1, 1));
`endif

    RESET = 1'b1; START = 1'b0; IN_VALID = 1'b0; IN_DATA = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ready", {31'd0, IN_READY}, 32'd0);
    check("rst_we", {31'd0, IMEM_WE}, 32'd0);
    check("rst_addr", 32'(IMEM_ADDR), 32'd0);
    check("rst_wdata", IMEM_WDATA, 32'd0);
    check("rst_core_rst_n", {31'd0, CORE_RESET_N}, 32'd0);
    check("rst_done", {31'd0, LOAD_DONE}, 32'd0);
    check("rst_err", {31'd0, LOAD_ERR}, 32'd0);
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("idle_ready", {31'd0, IN_READY}, 32'd0);

    foreach (vecs[i]) run_load(i, vecs[i]);

    // Stall for five cycles mid-word, with a START pulse that must be ignored.
    base = wr_addr.size();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    repeat (2) @(posedge CLK);
    #1;
    pulse_start();
    repeat (2) @(posedge CLK);
    #1;
    check("stall_no_write", 32'(wr_addr.size() - base), 32'd0);
    check("stall_ready", {31'd0, IN_READY}, 32'd1);
    send_byte(8'h33); send_byte(8'h44);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hAA);
`endif
    repeat (3) @(posedge CLK);
    #1;
    check("stall_write_count", 32'(wr_addr.size() - base), 32'd1);
    if (wr_addr.size() > base) begin
      check("stall_addr", 32'(wr_addr[base]), 32'd0);
      check("stall_data", wr_data[base], 32'h4433_2211);
    end
    check("stall_done", {31'd0, LOAD_DONE}, 32'd1);
    $display("stall load: writes=%0d done=%0b", wr_addr.size() - base, LOAD_DONE);

    // Asynchronous reset three bytes into a word: nothing may be written.
    base = wr_addr.size();
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    #2;
    RESET = 1'b1;
    #1;
    check("async_rst_ready", {31'd0, IN_READY}, 32'd0);
    check("async_rst_we", {31'd0, IMEM_WE}, 32'd0);
    check("async_rst_addr", 32'(IMEM_ADDR), 32'd0);
    check("async_rst_wdata", IMEM_WDATA, 32'd0);
    check("async_rst_core", {31'd0, CORE_RESET_N}, 32'd0);
    check("async_rst_done", {31'd0, LOAD_DONE}, 32'd0);
    check("async_rst_err", {31'd0, LOAD_ERR}, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("abort_no_write", 32'(wr_addr.size() - base), 32'd0);
    check("abort_idle_ready", {31'd0, IN_READY}, 32'd0);
    $display("reset abort: writes=%0d ready=%0b done=%0b", wr_addr.size() - base, IN_READY, LOAD_DONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
